// File: rtl/mdu_ctrl.sv
// Purpose : sequencing controller for the EX-stage multiply/divide units.
// Latency : multiply MUL_LATENCY+1 cycles to result_valid; divide = divider latency + 2 cycles.
// Backpres: stallreq_for_mdu holds EX until the result exists; DONE holds hi/lo while stall_hold=1.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush, stall_hold        pipeline flush (annuls work), downstream stall (hold result)
//   op_valid/op_mul/op_div/op_signed, src_a, src_b   operation issued from EX
//   mul_ina_o/mul_inb_o/mul_signed_o, mul_result_i   pipelined multiplier side
//   div_opdata1_o/div_opdata2_o/div_signed_o,
//   div_start_o/div_annul_o, div_ready_i, div_result_i  multi-cycle divider side
//   stallreq_for_mdu, result_valid, hi_o, lo_o        results back to the pipeline
//
// Optional build macro MDU_DIV0_FAST_EN: divide by zero bypasses the divider and
// completes directly with hi_o=src_a, lo_o=32'hFFFF_FFFF.
module mdu_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_hold,
  input  logic        op_valid,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] mul_ina_o,
  output logic [31:0] mul_inb_o,
  output logic        mul_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_signed_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  input  logic [63:0] mul_result_i,
  output logic        stallreq_for_mdu,
  output logic        result_valid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] opa, opa_nxt;
  logic [31:0] opb, opb_nxt;
  logic        sgn, sgn_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;

  logic        stall_c, valid_c, start_c, annul_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      sgn   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      sgn   <= sgn_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    opa_nxt   = opa;
    opb_nxt   = opb;
    sgn_nxt   = sgn;
    hi_nxt    = hi;
    lo_nxt    = lo;
    stall_c   = 1'b0;
    valid_c   = 1'b0;
    start_c   = 1'b0;
    annul_c   = 1'b0;

    case (state)
      IDLE: begin
        stall_c = op_valid & (op_mul | op_div);
        if (op_valid && !flush) begin
          // Multiply takes priority when both decode bits are set.
          if (op_mul) begin
            opa_nxt   = src_a;
            opb_nxt   = src_b;
            sgn_nxt   = op_signed;
            cnt_nxt   = 4'(MUL_LATENCY - 1);
            state_nxt = MUL;
          end else if (op_div) begin
            opa_nxt   = src_a;
            opb_nxt   = src_b;
            sgn_nxt   = op_signed;
`ifdef MDU_DIV0_FAST_EN
            if (src_b == 32'd0) begin
              hi_nxt    = src_a;
              lo_nxt    = 32'hFFFF_FFFF;
              state_nxt = DONE;
            end else begin
              state_nxt = DIV;
            end
`else
            state_nxt = DIV;
`endif
          end
        end
      end
      MUL: begin
        stall_c = 1'b1;
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          {hi_nxt, lo_nxt} = mul_result_i;
          state_nxt        = DONE;
        end
      end
      DIV: begin
        stall_c = 1'b1;
        start_c = 1'b1;
        if (div_ready_i) begin
          {hi_nxt, lo_nxt} = div_result_i;
          state_nxt        = DONE;
        end
      end
      DONE: begin
        valid_c = 1'b1;
        // Leaving on the cycle stall_hold drops: the pipeline advances with us,
        // so the same EX instruction is never seen as a new issue.
        if (!stall_hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Flush overrides everything: discard any result captured this cycle
    // (including a coincident div_ready_i) and cancel an active divide.
    if (flush) begin
      state_nxt = IDLE;
      hi_nxt    = hi;
      lo_nxt    = lo;
      stall_c   = 1'b0;
      valid_c   = 1'b0;
      start_c   = 1'b0;
      annul_c   = (state == DIV);
    end
  end

  // Combinational outputs are forced low during reset so no start/annul
  // pulse escapes from whatever state the reset interrupted.
  assign stallreq_for_mdu = stall_c & ~rst;
  assign result_valid     = valid_c & ~rst;
  assign div_start_o      = start_c & ~rst;
  assign div_annul_o      = annul_c & ~rst;

  assign mul_ina_o     = opa;
  assign mul_inb_o     = opb;
  assign mul_signed_o  = sgn;
  assign div_opdata1_o = opa;
  assign div_opdata2_o = opb;
  assign div_signed_o  = sgn;
  assign hi_o          = hi;
  assign lo_o          = lo;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the EX-stage multiply/divide resources. Accepts one mult/multu/div/divu operation per issue and latches its operands. It drives the multi-cycle divider's start/annul handshake and counts out the pipelined multiplier's fixed latency. It raises the EX stall request until the 64-bit {hi, lo} result is ready, then holds that result stable while later stages stall, and cancels in-flight work on flush.

## Interface
Parameters:
- MUL_LATENCY, default 1 — cycles from multiplier operand presentation to valid `mul_result_i`; legal range 1–15.

Ports:
- clk  in  1  — clock.
- rst  in  1  — reset; one clock, synchronous, active-high.
- flush  in  1  — pipeline flush; annuls any operation in progress.
- stall_hold  in  1  — downstream stage stalled (stall[3]); result must be held.
- op_valid  in  1  — EX holds a mult/div instruction this cycle.
- op_mul  in  1  — operation is multiply.
- op_div  in  1  — operation is divide.
- op_signed  in  1  — signed variant (mult/div).
- src_a  in  32  — rs operand (dividend / multiplicand).
- src_b  in  32  — rt operand (divisor / multiplier).
- mul_ina_o, mul_inb_o  out  32 each  — latched multiplier operands.
- mul_signed_o  out  1  — latched signedness for the multiplier.
- div_opdata1_o, div_opdata2_o  out  32 each  — latched divider operands.
- div_signed_o  out  1  — latched signedness for the divider.
- div_start_o  out  1  — divider start, held high while dividing.
- div_annul_o  out  1  — divider cancel.
- div_ready_i  in  1  — divider result ready.
- div_result_i  in  64  — {remainder, quotient}.
- mul_result_i  in  64  — {hi, lo} product.
- stallreq_for_mdu  out  1  — EX stall request.
- result_valid  out  1  — hi_o/lo_o valid for the instruction in EX.
- hi_o, lo_o  out  32 each  — captured result.

## Operation
- States: IDLE, MUL, DIV, DONE. Operand and result registers are all 0 at reset.
- IDLE:
  - op_valid & op_mul & !flush: latch src_a, src_b, op_signed; load cnt = MUL_LATENCY-1; go to MUL.
  - else op_valid & op_div & !flush: latch the same operands; go to DIV.
  - op_mul & op_div both set: multiply wins.
- MUL:
  - cnt≠0: decrement.
  - cnt==0: capture mul_result_i into {hi_o, lo_o}; go to DONE.
- DIV:
  - div_start_o=1.
  - div_ready_i=1: capture div_result_i; go to DONE.
- DONE:
  - result_valid=1.
  - Registers held while stall_hold=1.
  - stall_hold=0: go to IDLE. The pipeline advances that cycle, so the same instruction is never re-accepted.
- Flush:
  - In any state, flush=1 sends the next state to IDLE and clears result_valid.
  - In DIV, div_annul_o=1 and div_start_o=0 that cycle.
  - A div_ready_i coincident with flush is discarded.
- stallreq_for_mdu (combinational) = !flush & ((IDLE & op_valid & (op_mul|op_div)) | MUL | DIV).
- Operand outputs always reflect the latched registers; only div_start_o gates the divider.
- Reset in any state: IDLE, all outputs 0, div_start_o=0, no annul pulse.

## Timing
- Acceptance cycle = T0; stall is asserted from T0.
- Multiply:
  - MUL occupies T1..T_MUL_LATENCY.
  - Result captured at the end of T_MUL_LATENCY; result_valid from T_MUL_LATENCY+1.
  - Stall asserted T0..T_MUL_LATENCY (MUL_LATENCY+1 cycles).
- Divide:
  - div_start_o high from T1 until the cycle div_ready_i is sampled high, inclusive.
  - result_valid the following cycle.
- Stall deasserts in the same cycle result_valid rises.
- Back-to-back ops: a new op is accepted earliest the cycle after DONE exits (IDLE).

## Configuration
- MDU_DIV0_FAST_EN:
  - Defined: a divide whose src_b==0 skips the divider and goes IDLE→DONE directly with hi_o=src_a, lo_o=32'hFFFF_FFFF.
    - div_start_o is never raised.
    - Stall is asserted only at T0.
  - Undefined: divide-by-zero is issued to the divider like any other divide and returns whatever the divider produces.

## Test plan
- multu 0xFFFF_FFFF × 2, MUL_LATENCY=1, stall_hold=0 -> stall high for 2 cycles; then hi_o=0x1, lo_o=0xFFFF_FFFE, result_valid=1 for 1 cycle.
- div −7 ÷ 2, divider model ready after 33 cycles -> div_start_o high 33 cycles; hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFD; stall drops with result_valid.
- Result with stall_hold=1 for 4 cycles -> hi_o/lo_o/result_valid stable 5 cycles; no second div_start_o.
- flush at DIV cycle 10 -> div_annul_o pulse 1 cycle; next cycle IDLE, stall 0, result_valid 0.
- div_ready_i and flush in the same cycle -> result not captured; state IDLE.
- divu 5 ÷ 0 with MDU_DIV0_FAST_EN -> no div_start_o; next cycle hi_o=5, lo_o=0xFFFF_FFFF.
